fetch_redirect_controller: RTL and testbench

FETCH_REDIRECT_CONTROLLER -- requirements
Module: fetch_redirect_controller

---
 rtl/fetch_redirect_controller.sv | 167 ++++++++++++++++
 tb/tb_fetch_redirect_controller.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/fetch_redirect_controller.sv
// fetch_redirect_controller
//   Front-end pipeline steering. It tracks the oldest unresolved control-flow
//   event and drives the per-stage stall/flush controls, the redirect PC, and
//   two saturating performance counters.
//
//   States:
//     RUN      - normal flow. Load-use hazards stall fetch/decode here.
//     BR_WAIT  - an unpredicted branch is in flight. Fetch is held until it
//                resolves.
//     REDIRECT - a single cycle that presents the corrected PC on irreg_pc.
//
//   Ports:
//     clk, rst            - clock; synchronous active-low reset
//     fetch_is_branch     - fetch-stage instruction is a branch/jump
//     fetch_pc_predicted  - fetch-stage next PC came from the predictor
//     dec_load_use        - decode detects a load-use hazard
//     resolve_valid       - a branch resolved this cycle
//     resolve_mispredict  - the resolved branch left the fetched path
//     resolve_target      - correct next PC of the resolved branch
//     fetch_stall, fetch_flush, decode_stall, decode_flush, execute_flush
//                         - per-stage pipeline controls
//     irreg_pc            - redirect PC (0 = no redirect)
//     mispredict_cnt      - number of REDIRECT entries (saturating)
//     stall_cnt           - number of cycles with fetch_stall=1 (saturating)
//
//   Build option:
//     BRANCH_RESOLVE_MEM_EN - branches resolve in the memory stage, so the
//     instruction in execute is on the wrong path as well. In that case
//     execute_flush is also raised in REDIRECT and on BR_WAIT exit. When the
//     macro is undefined, branches resolve in execute and execute_flush only
//     marks load-use bubbles.
module fetch_redirect_controller #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_is_branch,
  input  logic                  fetch_pc_predicted,
  input  logic                  dec_load_use,
  input  logic                  resolve_valid,
  input  logic                  resolve_mispredict,
  input  logic [ADDR_WIDTH-1:0] resolve_target,
  output logic                  fetch_stall,
  output logic                  fetch_flush,
  output logic                  decode_stall,
  output logic                  decode_flush,
  output logic                  execute_flush,
  output logic [ADDR_WIDTH-1:0] irreg_pc,
  output logic [CNT_WIDTH-1:0]  mispredict_cnt,
  output logic [CNT_WIDTH-1:0]  stall_cnt
);

`ifdef BRANCH_RESOLVE_MEM_EN
  localparam logic RESOLVE_IN_MEM = 1'b1;
`else
  localparam logic RESOLVE_IN_MEM = 1'b0;
`endif

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    BR_WAIT  = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_target;
  logic [CNT_WIDTH-1:0]  r_mispredict_cnt;
  logic [CNT_WIDTH-1:0]  r_stall_cnt;

  logic                  w_mispredict;
  logic                  w_enter_redirect;
  logic                  w_fetch_stall;
  logic                  w_decode_stall;
  logic                  w_decode_flush;
  logic                  w_execute_flush;
  logic [ADDR_WIDTH-1:0] w_irreg_pc;

  assign w_mispredict = resolve_valid & resolve_mispredict;

  always_comb begin
    w_state_next    = r_state;
    w_fetch_stall   = 1'b0;
    w_decode_stall  = 1'b0;
    w_decode_flush  = 1'b0;
    w_execute_flush = 1'b0;
    w_irreg_pc      = '0;

    case (r_state)
      RUN: begin
        // Priority: mispredict, then load-use, then a new unpredicted branch.
        // A mispredict suppresses the load-use stall entirely because the
        // stalled instruction is on the wrong path anyway.
        if (w_mispredict) begin
          w_state_next = REDIRECT;
        end else if (dec_load_use) begin
          w_fetch_stall   = 1'b1;
          w_decode_stall  = 1'b1;
          w_execute_flush = 1'b1;
        end else if (fetch_is_branch && !fetch_pc_predicted) begin
          w_state_next = BR_WAIT;
        end
      end

      BR_WAIT: begin
        // Held through the resolving cycle as well, so each waiting cycle
        // counts as a stall.
        w_fetch_stall  = 1'b1;
        w_decode_flush = 1'b1;
        if (resolve_valid) begin
          w_execute_flush = RESOLVE_IN_MEM;
          w_state_next    = resolve_mispredict ? REDIRECT : RUN;
        end
      end

      REDIRECT: begin
        // A zero target shows up as irreg_pc=0, which downstream reads as
        // "no redirect". The event is still counted.
        w_irreg_pc      = r_target;
        w_decode_flush  = 1'b1;
        w_execute_flush = RESOLVE_IN_MEM;
        w_state_next    = RUN;
      end

      default: begin
        w_state_next = RUN;
      end
    endcase

    w_enter_redirect = (w_state_next == REDIRECT) && (r_state != REDIRECT);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state          <= RUN;
      r_target         <= '0;
      r_mispredict_cnt <= '0;
      r_stall_cnt      <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_enter_redirect) begin
        r_target <= resolve_target;
        if (r_mispredict_cnt != {CNT_WIDTH{1'b1}}) begin
          r_mispredict_cnt <= r_mispredict_cnt + CNT_ONE;
        end
      end
      if (w_fetch_stall && (r_stall_cnt != {CNT_WIDTH{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end
    end
  end

  // Controls are forced quiet while reset is held, even before the first
  // edge has cleared the state register.
  assign fetch_stall    = rst & w_fetch_stall;
  assign fetch_flush    = 1'b0;
  assign decode_stall   = rst & w_decode_stall;
  assign decode_flush   = rst & w_decode_flush;
  assign execute_flush  = rst & w_execute_flush;
  assign irreg_pc       = rst ? w_irreg_pc : '0;
  assign mispredict_cnt = r_mispredict_cnt;
  assign stall_cnt      = r_stall_cnt;

endmodule

// File: tb/tb_fetch_redirect_controller.sv
// Directed bench for fetch_redirect_controller with a scoreboard queue.
// Inputs are driven on the falling edge. The expected outputs for that cycle
// are pushed to the queue, then popped and compared 1 ns later.
module tb_fetch_redirect_controller;
  localparam int AW = 32;
  localparam int CW = 16;

`ifdef BRANCH_RESOLVE_MEM_EN
  localparam logic MEMF = 1'b1;
`else
  localparam logic MEMF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          fetch_is_branch, fetch_pc_predicted, dec_load_use;
  logic          resolve_valid, resolve_mispredict;
  logic [AW-1:0] resolve_target;
  logic          fetch_stall, fetch_flush, decode_stall, decode_flush, execute_flush;
  logic [AW-1:0] irreg_pc;
  logic [CW-1:0] mispredict_cnt, stall_cnt;

  always #5 clk = ~clk;

  fetch_redirect_controller #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk                (clk),
    .rst                (rst),
    .fetch_is_branch    (fetch_is_branch),
    .fetch_pc_predicted (fetch_pc_predicted),
    .dec_load_use       (dec_load_use),
    .resolve_valid      (resolve_valid),
    .resolve_mispredict (resolve_mispredict),
    .resolve_target     (resolve_target),
    .fetch_stall        (fetch_stall),
    .fetch_flush        (fetch_flush),
    .decode_stall       (decode_stall),
    .decode_flush       (decode_flush),
    .execute_flush      (execute_flush),
    .irreg_pc           (irreg_pc),
    .mispredict_cnt     (mispredict_cnt),
    .stall_cnt          (stall_cnt)
  );

  typedef struct packed {
    logic          fs;
    logic          ff;
    logic          ds;
    logic          df;
    logic          ef;
    logic [AW-1:0] pc;
    logic [CW-1:0] mc;
    logic [CW-1:0] sc;
  } exp_t;

  exp_t          sb_q[$];
  int            tests = 0;
  int            fails = 0;
  logic [CW-1:0] exp_mc = '0;
  logic [CW-1:0] exp_sc = '0;

  task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, expv);
    end
  endtask

  // One cycle: drive the inputs, push the expected outputs, compare, and then
  // advance the counter model for the coming edge.
  // ent = this cycle enters REDIRECT.
  task automatic step(input string name, input logic r, input logic lu, input logic br,
                      input logic pr, input logic rv, input logic rm, input logic [AW-1:0] tg,
                      input logic e_fs, input logic e_ds, input logic e_df, input logic e_ef,
                      input logic [AW-1:0] e_pc, input logic ent);
    exp_t e;
    exp_t g;
    @(negedge clk);
    rst = r; dec_load_use = lu; fetch_is_branch = br; fetch_pc_predicted = pr;
    resolve_valid = rv; resolve_mispredict = rm; resolve_target = tg;
    e = '{fs: e_fs, ff: 1'b0, ds: e_ds, df: e_df, ef: e_ef, pc: e_pc, mc: exp_mc, sc: exp_sc};
    sb_q.push_back(e);
    #1;
    g = sb_q.pop_front();
    chk({name, ".fetch_stall"},    AW'(fetch_stall),    AW'(g.fs));
    chk({name, ".fetch_flush"},    AW'(fetch_flush),    AW'(g.ff));
    chk({name, ".decode_stall"},   AW'(decode_stall),   AW'(g.ds));
    chk({name, ".decode_flush"},   AW'(decode_flush),   AW'(g.df));
    chk({name, ".execute_flush"},  AW'(execute_flush),  AW'(g.ef));
    chk({name, ".irreg_pc"},       irreg_pc,            g.pc);
    chk({name, ".mispredict_cnt"}, AW'(mispredict_cnt), AW'(g.mc));
    chk({name, ".stall_cnt"},      AW'(stall_cnt),      AW'(g.sc));
    $display("[TB] %s fs=%0b ds=%0b df=%0b ef=%0b pc=%0h mc=%0d sc=%0d",
             name, fetch_stall, decode_stall, decode_flush, execute_flush,
             irreg_pc, mispredict_cnt, stall_cnt);
    if (!r) begin
      exp_mc = '0;
      exp_sc = '0;
    end else begin
      if (ent && exp_mc != '1) exp_mc = exp_mc + 1'b1;
      if (e_fs && exp_sc != '1) exp_sc = exp_sc + 1'b1;
    end
  endtask

  initial begin
    rst = 1'b0; dec_load_use = 1'b0; fetch_is_branch = 1'b0; fetch_pc_predicted = 1'b0;
    resolve_valid = 1'b0; resolve_mispredict = 1'b0; resolve_target = '0;
    repeat (2) @(posedge clk);

    //   name         r  lu br pr rv rm target        fs ds df ef    pc       ent
    step("reset_idle", 1, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0,    32'h0,   0);
    step("mp_resolve", 1, 0, 0, 0, 1, 1, 32'h100,      0, 0, 0, 0,    32'h0,   1);
    step("mp_redir",   1, 0, 0, 0, 0, 0, 32'h0,        0, 0, 1, MEMF, 32'h100, 0);
    step("mp_after",   1, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0,    32'h0,   0);
    step("br_issue",   1, 0, 1, 0, 0, 0, 32'h0,        0, 0, 0, 0,    32'h0,   0);
    step("br_wait1",   1, 0, 0, 0, 0, 0, 32'h0,        1, 0, 1, 0,    32'h0,   0);
    step("br_wait2",   1, 0, 0, 0, 0, 0, 32'h0,        1, 0, 1, 0,    32'h0,   0);
    step("br_resolve", 1, 0, 0, 0, 1, 0, 32'h0,        1, 0, 1, MEMF, 32'h0,   0);
    step("br_after",   1, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0,    32'h0,   0);
    step("br_pred",    1, 0, 1, 1, 0, 0, 32'h0,        0, 0, 0, 0,    32'h0,   0);
    step("simul_mp",   1, 1, 0, 0, 1, 1, 32'h200,      0, 0, 0, 0,    32'h0,   1);
    step("simul_redir",1, 1, 1, 0, 0, 0, 32'h0,        0, 0, 1, MEMF, 32'h200, 0);
    step("simul_after",1, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0,    32'h0,   0);
    step("load_use",   1, 1, 0, 0, 0, 0, 32'h0,        1, 1, 0, 1,    32'h0,   0);
    step("lu_vs_br",   1, 1, 1, 0, 0, 0, 32'h0,        1, 1, 0, 1,    32'h0,   0);
    step("lu_after",   1, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0,    32'h0,   0);
    step("zero_mp",    1, 0, 0, 0, 1, 1, 32'h0,        0, 0, 0, 0,    32'h0,   1);
    step("zero_redir", 1, 0, 0, 0, 0, 0, 32'h0,        0, 0, 1, MEMF, 32'h0,   0);
    step("zero_after", 1, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0,    32'h0,   0);
    step("bw_mp_issue",1, 0, 1, 0, 0, 0, 32'h0,        0, 0, 0, 0,    32'h0,   0);
    step("bw_mp_res",  1, 0, 0, 0, 1, 1, 32'h300,      1, 0, 1, MEMF, 32'h0,   1);
    step("bw_mp_redir",1, 0, 0, 0, 0, 0, 32'h0,        0, 0, 1, MEMF, 32'h300, 0);
    step("bw_mp_after",1, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0,    32'h0,   0);
    step("rst_issue",  1, 0, 1, 0, 0, 0, 32'h0,        0, 0, 0, 0,    32'h0,   0);
    step("rst_wait",   1, 0, 0, 0, 0, 0, 32'h0,        1, 0, 1, 0,    32'h0,   0);
    step("rst_assert", 0, 0, 0, 0, 1, 1, 32'h400,      0, 0, 0, 0,    32'h0,   0);
    step("rst_run1",   1, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0,    32'h0,   0);
    step("rst_run2",   1, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0,    32'h0,   0);

    // Saturation: hold load-use for 2^CW + 5 cycles.
    @(negedge clk);
    dec_load_use = 1'b1;
    for (int i = 0; i < (1 << CW) + 5; i++) begin
      @(negedge clk);
      if (exp_sc != '1) exp_sc = exp_sc + 1'b1;
    end
    dec_load_use = 1'b0;
    $display("[TB] saturation run done, stall_cnt=%0h", stall_cnt);
    step("sat_idle",   1, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0,    32'h0,   0);
    chk("sat_value", AW'(stall_cnt), 32'h0000_FFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
